// File: rtl/mbox_sbus_seq_pkg.sv
// mbox_sbus_seq_pkg
//   Shared definitions for the MBOX SBUS cycle sequencer: FSM state type,
//   bank-select bit index, timeout counter width, and quadword mask helpers.
package mbox_sbus_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // PMA bit that selects memory bank B (1) or bank A (0)
  localparam int unsigned BANK_BIT = 21;

  // Width of the optional no-progress counter
  localparam int unsigned TO_W = 6;

  // Number of words selected in a quadword mask
  function automatic logic [2:0] popcount4(input logic [3:0] m);
    logic [2:0] c;
    c = '0;
    for (int unsigned k = 0; k < 4; k++) c = c + {2'b00, m[k]};
    return c;
  endfunction

  // Index of the lowest set bit (next word to transfer); 0 for an empty mask
  function automatic logic [1:0] first_set(input logic [3:0] m);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (m[k] && !found) begin
        idx   = k[1:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mbox_sbus_rr_arb.sv
// mbox_sbus_rr_arb
//   Two-input round-robin arbiter. The last-granted requester loses a tie;
//   after reset requester 0 has priority.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req[1:0]     : request levels
//   i_take         : grant is being consumed this cycle (updates pointer)
//   o_gnt[1:0]     : combinational one-hot grant (zero when no request)
module mbox_sbus_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  // 1: requester 1 wins a tie (requester 0 was granted last)
  logic r_pri_r1;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = r_pri_r1 ? 2'b10 : 2'b01;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 r_pri_r1 <= 1'b0;
    else if (i_take && |o_gnt)    r_pri_r1 <= o_gnt[0];
  end

endmodule

// File: rtl/mbox_sbus_seq.sv
// mbox_sbus_seq
//   Sequences SBUS memory cycles for two MBOX requesters (R0 cache, R1 chan).
//   Arbitrates round-robin, captures address/mask/direction, drives the bank
//   start / request / address-hold controls, tracks ACKN and data-valid, and
//   reports word strobes, completion and error to the winning requester.
//   Optional: define MBOX_SBUS_TIMEOUT_EN for a 6-bit no-progress timeout.
// Ports
//   CLK, CROBAR_N         : clock, asynchronous active-low reset
//   REQ/WR[1:0]           : per-requester request level and write flag
//   RQ_MASK[7:0]          : R1 mask in [7:4], R0 mask in [3:0]
//   ADR[43:0]             : R1 address in [43:22], R0 address in [21:0]
//   GNT, BUSY, WORD_STB, WORD_IDX, DONE, ERR : requester-side status
//   MEM_* / SBUS_ADR_HOLD / PMA / DATA_VALID_*_OUT : translator-side controls
//   MEM_ACKN_*, MEM_DATA_VALID_*, MEM_ERROR, MEM_ADR_PAR_ERR : memory responses
module mbox_sbus_seq
  import mbox_sbus_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        CROBAR_N,
  input  logic [1:0]  REQ,
  input  logic [1:0]  WR,
  input  logic [7:0]  RQ_MASK,
  input  logic [43:0] ADR,
  output logic [1:0]  GNT,
  output logic        BUSY,
  output logic        WORD_STB,
  output logic [1:0]  WORD_IDX,
  output logic        DONE,
  output logic        ERR,
  output logic        MEM_START_A,
  output logic        MEM_START_B,
  output logic [3:0]  MEM_RQ,
  output logic        MEM_RD_RQ,
  output logic        MEM_WR_RQ,
  output logic        SBUS_ADR_HOLD,
  output logic [21:0] PMA,
  output logic        MEM_ADR_PAR,
  output logic        MEM_DATA_TO_MEM,
  output logic        DATA_VALID_A_OUT,
  output logic        DATA_VALID_B_OUT,
  input  logic        MEM_ACKN_A,
  input  logic        MEM_ACKN_B,
  input  logic        MEM_DATA_VALID_A,
  input  logic        MEM_DATA_VALID_B,
  input  logic        MEM_ERROR,
  input  logic        MEM_ADR_PAR_ERR
);

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_gnt;
  logic [21:0] r_pma;
  logic        r_par;
  logic [3:0]  r_mask;
  logic [3:0]  r_rem;
  logic [2:0]  r_cnt;
  logic        r_wr;
  logic        r_err;

  logic [1:0]  w_gnt;
  logic        w_take;
  logic [3:0]  w_mask_in;
  logic [21:0] w_adr_in;
  logic        w_wr_in;
  logic        w_bank_b;
  logic        w_ack;
  logic        w_dv;
  logic        w_fault;
  logic        w_start_act;
  logic        w_word;
  logic [1:0]  w_idx;
  logic        w_err_set;
  logic        w_to_hit;

  mbox_sbus_rr_arb u_arb (
    .i_clk   (CLK),
    .i_rst_n (CROBAR_N),
    .i_req   (REQ),
    .i_take  (w_take),
    .o_gnt   (w_gnt)
  );

  always_comb begin
    w_take    = (r_state == ST_IDLE) && (REQ != 2'b00);
    w_mask_in = w_gnt[1] ? RQ_MASK[7:4] : RQ_MASK[3:0];
    w_adr_in  = w_gnt[1] ? ADR[43:22]   : ADR[21:0];
    w_wr_in   = w_gnt[1] ? WR[1]        : WR[0];
    w_bank_b  = r_pma[BANK_BIT];
    w_ack     = w_bank_b ? MEM_ACKN_B       : MEM_ACKN_A;
    w_dv      = w_bank_b ? MEM_DATA_VALID_B : MEM_DATA_VALID_A;
    w_fault   = MEM_ERROR || MEM_ADR_PAR_ERR;
    // START and FIN are entered together with the GNT pulse; their SBUS and
    // completion activity begins the cycle after GNT.
    w_start_act = (r_state == ST_START) && (r_gnt == 2'b00);
    w_word      = (r_state == ST_XFER) && (r_wr || w_dv);
    w_idx       = first_set(r_rem);
  end

`ifdef MBOX_SBUS_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  logic [TO_W-1:0] r_to;
  logic            w_watch;
  logic            w_progress;

  always_comb begin
    w_watch    = w_start_act || (r_state == ST_XFER);
    w_progress = (w_start_act && w_ack) || w_word;
    // Reaching the terminal count in this cycle ends the bus cycle
    w_to_hit   = w_watch && !w_progress && (r_to == TO_LAST);
  end

  always_ff @(posedge CLK or negedge CROBAR_N) begin
    if (!CROBAR_N)                    r_to <= '0;
    else if (!w_watch || w_progress)  r_to <= '0;
    else                              r_to <= r_to + 1'b1;
  end
`else
  always_comb w_to_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_take) w_state_nxt = (w_mask_in == 4'b0000) ? ST_FIN : ST_START;
      ST_START: begin
        if (w_start_act) begin
          if (w_fault || w_to_hit) begin
            w_state_nxt = ST_FIN;
            w_err_set   = 1'b1;
          end else if (w_ack) begin
            w_state_nxt = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        if (w_fault || w_to_hit) begin
          w_state_nxt = ST_FIN;
          w_err_set   = 1'b1;
        end else if (w_word && (r_cnt == 3'd1)) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN:   if (r_gnt == 2'b00) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CROBAR_N) begin
    if (!CROBAR_N) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_pma   <= '0;
      r_par   <= 1'b0;
      r_mask  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_take ? w_gnt : 2'b00;
      if (w_take) begin
        r_pma  <= w_adr_in;
        r_par  <= ~^w_adr_in;
        r_mask <= w_mask_in;
        r_rem  <= w_mask_in;
        r_cnt  <= popcount4(w_mask_in);
        r_wr   <= w_wr_in;
        r_err  <= 1'b0;
      end else begin
        if (w_word) begin
          r_cnt <= r_cnt - 3'd1;
          r_rem <= r_rem & ~(4'b0001 << w_idx);
        end
        if (w_err_set) r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    GNT              = r_gnt;
    BUSY             = (r_state != ST_IDLE);
    WORD_STB         = w_word;
    WORD_IDX         = w_word ? w_idx : 2'b00;
    DONE             = (r_state == ST_FIN) && (r_gnt == 2'b00);
    ERR              = DONE && r_err;
    MEM_START_A      = w_start_act && !w_bank_b;
    MEM_START_B      = w_start_act && w_bank_b;
    MEM_RQ           = w_start_act ? r_mask : 4'b0000;
    MEM_RD_RQ        = w_start_act && !r_wr;
    MEM_WR_RQ        = w_start_act && r_wr;
    SBUS_ADR_HOLD    = w_start_act;
    PMA              = r_pma;
    MEM_ADR_PAR      = r_par;
    MEM_DATA_TO_MEM  = (r_state == ST_XFER) && r_wr;
    DATA_VALID_A_OUT = (r_state == ST_XFER) && r_wr && !w_bank_b;
    DATA_VALID_B_OUT = (r_state == ST_XFER) && r_wr && w_bank_b;
  end

endmodule

// File: tb/tb_mbox_sbus_seq.sv
module tb_mbox_sbus_seq;

  logic        CLK;
  logic        CROBAR_N;
  logic [1:0]  REQ, WR;
  logic [7:0]  RQ_MASK;
  logic [43:0] ADR;
  logic [1:0]  GNT;
  logic        BUSY, WORD_STB, DONE, ERR;
  logic [1:0]  WORD_IDX;
  logic        MEM_START_A, MEM_START_B, MEM_RD_RQ, MEM_WR_RQ, SBUS_ADR_HOLD;
  logic [3:0]  MEM_RQ;
  logic [21:0] PMA;
  logic        MEM_ADR_PAR, MEM_DATA_TO_MEM, DATA_VALID_A_OUT, DATA_VALID_B_OUT;
  logic        MEM_ACKN_A, MEM_ACKN_B, MEM_DATA_VALID_A, MEM_DATA_VALID_B;
  logic        MEM_ERROR, MEM_ADR_PAR_ERR;

  int n_cmp  = 0;
  int n_fail = 0;
  int last_r = 1;   // model of "last granted"; 1 after reset gives R0 priority

  mbox_sbus_seq dut (
    .CLK(CLK), .CROBAR_N(CROBAR_N), .REQ(REQ), .WR(WR), .RQ_MASK(RQ_MASK), .ADR(ADR),
    .GNT(GNT), .BUSY(BUSY), .WORD_STB(WORD_STB), .WORD_IDX(WORD_IDX), .DONE(DONE),
    .ERR(ERR), .MEM_START_A(MEM_START_A), .MEM_START_B(MEM_START_B), .MEM_RQ(MEM_RQ),
    .MEM_RD_RQ(MEM_RD_RQ), .MEM_WR_RQ(MEM_WR_RQ), .SBUS_ADR_HOLD(SBUS_ADR_HOLD),
    .PMA(PMA), .MEM_ADR_PAR(MEM_ADR_PAR), .MEM_DATA_TO_MEM(MEM_DATA_TO_MEM),
    .DATA_VALID_A_OUT(DATA_VALID_A_OUT), .DATA_VALID_B_OUT(DATA_VALID_B_OUT),
    .MEM_ACKN_A(MEM_ACKN_A), .MEM_ACKN_B(MEM_ACKN_B),
    .MEM_DATA_VALID_A(MEM_DATA_VALID_A), .MEM_DATA_VALID_B(MEM_DATA_VALID_B),
    .MEM_ERROR(MEM_ERROR), .MEM_ADR_PAR_ERR(MEM_ADR_PAR_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {21'd0, GNT, BUSY, WORD_STB, WORD_IDX, DONE, ERR, MEM_START_A, MEM_START_B,
            MEM_RQ, MEM_RD_RQ, MEM_WR_RQ, SBUS_ADR_HOLD, PMA, MEM_ADR_PAR,
            MEM_DATA_TO_MEM, DATA_VALID_A_OUT, DATA_VALID_B_OUT};
  endfunction

  task automatic idle_inputs();
    REQ = '0; WR = '0; RQ_MASK = '0; ADR = '0;
    MEM_ACKN_A = 0; MEM_ACKN_B = 0; MEM_DATA_VALID_A = 0; MEM_DATA_VALID_B = 0;
    MEM_ERROR = 0; MEM_ADR_PAR_ERR = 0;
  endtask

  // One complete bus cycle for requester r. err_after: word count at which an
  // error is injected (-1 = none); err_dv: data-valid alongside that error.
  task automatic run_txn(input int r, input logic wr, input logic [3:0] mask,
                         input logic [21:0] adr, input int ack_dly,
                         input int err_after, input logic err_dv, input logic gaps);
    int   exp_idx[$];
    int   ones, n, guard;
    logic bank_b, par, dv, err_hit, exp_stb, noise;
    logic [1:0] exp_g;
    for (int k = 0; k < 4; k++) if (mask[k]) exp_idx.push_back(k);
    ones = 0;
    for (int k = 0; k < 22; k++) ones += int'(adr[k]);
    par    = (ones % 2 == 0);          // odd parity: total ones incl. parity is odd
    bank_b = adr[21];
    exp_g  = (r == 0) ? 2'b01 : 2'b10;

    @(negedge CLK);
    idle_inputs();
    REQ[r] = 1'b1; WR[r] = wr; RQ_MASK[r*4 +: 4] = mask; ADR[r*22 +: 22] = adr;
    #1 chk("idle_busy", BUSY, 0);

    @(negedge CLK);
    REQ = '0;
    #1;
    chk("gnt", GNT, exp_g);
    chk("gnt_busy", BUSY, 1);
    chk("pma", PMA, adr);
    chk("par", MEM_ADR_PAR, par);
    chk("gnt_quiet", {MEM_START_A, MEM_START_B, SBUS_ADR_HOLD, DONE}, 0);
    last_r = r;

    err_hit = 0;
    if (mask == 4'b0000) begin
      @(negedge CLK); #1;
      chk("m0_done", {DONE, ERR}, 2'b10);
      chk("m0_nosbus", {MEM_START_A, MEM_START_B, SBUS_ADR_HOLD, MEM_RQ, MEM_RD_RQ, MEM_WR_RQ}, 0);
    end else begin
      for (int d = 0; d <= ack_dly; d++) begin
        @(negedge CLK);
        noise = 1'($urandom_range(0, 1));
        if (bank_b) begin MEM_ACKN_B = (d == ack_dly); MEM_ACKN_A = noise; end
        else        begin MEM_ACKN_A = (d == ack_dly); MEM_ACKN_B = noise; end
        #1;
        chk("start_ab", {MEM_START_A, MEM_START_B}, {!bank_b, bank_b});
        chk("start_hold", {SBUS_ADR_HOLD, MEM_RQ}, {1'b1, mask});
        chk("start_rdwr", {MEM_RD_RQ, MEM_WR_RQ}, {!wr, wr});
        chk("start_quiet", {WORD_STB, DONE, GNT, MEM_DATA_TO_MEM}, 0);
      end
      n = 0; guard = 0;
      while (n < exp_idx.size() && !err_hit && guard < 64) begin
        guard++;
        @(negedge CLK);
        MEM_ACKN_A = 0; MEM_ACKN_B = 0; MEM_ERROR = 0; MEM_ADR_PAR_ERR = 0;
        dv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        err_hit = (err_after == n);
        if (err_hit) begin
          dv = err_dv;
          if ($urandom_range(0, 1) == 1) MEM_ERROR = 1; else MEM_ADR_PAR_ERR = 1;
        end
        noise = 1'($urandom_range(0, 1));
        if (wr) dv = 1'($urandom_range(0, 1));     // ignored by a write
        if (bank_b) begin MEM_DATA_VALID_B = dv; MEM_DATA_VALID_A = noise; end
        else        begin MEM_DATA_VALID_A = dv; MEM_DATA_VALID_B = noise; end
        #1;
        exp_stb = wr ? 1'b1 : dv;
        chk("word_stb", WORD_STB, exp_stb);
        if (exp_stb) chk("word_idx", WORD_IDX, exp_idx[n]);
        chk("dv_out", {DATA_VALID_A_OUT, DATA_VALID_B_OUT}, {wr && !bank_b, wr && bank_b});
        chk("to_mem", MEM_DATA_TO_MEM, wr);
        chk("xfer_quiet", {DONE, SBUS_ADR_HOLD, MEM_START_A, MEM_START_B}, 0);
        if (exp_stb) n++;
      end
      if (guard >= 64) chk("xfer_bound", n, exp_idx.size());
      @(negedge CLK);
      idle_inputs();
      #1;
      chk("done", {DONE, ERR}, {1'b1, err_hit});
      chk("done_quiet", {WORD_STB, MEM_DATA_TO_MEM, BUSY}, 3'b001);
    end
    @(negedge CLK); #1;
    chk("after_done", {BUSY, DONE, ERR}, 0);
  endtask

  // Waits (bounded) for a grant and compares it with the round-robin model
  task automatic expect_grant(input string tag);
    logic [1:0] exp_g;
    exp_g = (last_r == 0) ? 2'b10 : 2'b01;
    for (int w = 0; w < 6; w++) begin
      @(negedge CLK); #1;
      if (GNT != 2'b00) break;
    end
    chk(tag, GNT, exp_g);
    last_r = (exp_g == 2'b10) ? 1 : 0;
  endtask

  initial begin
    logic [21:0] a;
    logic [3:0]  m;
    logic        w;
    idle_inputs();
    CROBAR_N = 0;
    repeat (3) @(negedge CLK);
    #1 chk("reset_outs", all_out(), 0);
    @(negedge CLK);
    CROBAR_N = 1;

    run_txn(0, 1'b0, 4'b1111, 22'o0001000, 2, -1, 1'b0, 1'b0);
    a = 22'($urandom); a[21] = 1'b1;
    run_txn(1, 1'b1, 4'b0101, a, 0, -1, 1'b0, 1'b0);
    a = 22'($urandom); a[21] = 1'b0;
    run_txn(0, 1'b0, 4'b1011, a, 1, 1, 1'b0, 1'b0);     // error after first word
    a = 22'($urandom); a[21] = 1'b1;
    run_txn(1, 1'b0, 4'b0011, a, 0, 1, 1'b1, 1'b0);     // error with last word
    run_txn(0, 1'b1, 4'b0000, 22'($urandom), 0, -1, 1'b0, 1'b0);

    // Both requesting continuously: grants alternate, never both
    @(negedge CLK);
    REQ = 2'b11; RQ_MASK = '0;
    for (int g = 0; g < 6; g++) expect_grant("rr_gnt");
    @(negedge CLK);
    REQ = '0;
    repeat (3) @(negedge CLK);

    for (int t = 0; t < 24; t++) begin
      a = 22'($urandom);
      m = 4'($urandom);
      w = 1'($urandom_range(0, 1));
      run_txn(int'($urandom_range(0, 1)), w, m, a, int'($urandom_range(0, 3)),
              (w == 1'b0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1,
              1'($urandom_range(0, 1)), 1'b1);
    end

`ifdef MBOX_SBUS_TIMEOUT_EN
    begin
      int t;
      @(negedge CLK);
      REQ[0] = 1; WR[0] = 0; RQ_MASK[3:0] = 4'b0001; ADR[21:0] = 22'h000040;
      @(negedge CLK);
      REQ = '0;
      last_r = 0;
      for (t = 0; t < 80; t++) begin
        @(negedge CLK); #1;
        if (DONE) break;
      end
      chk("to_cycles", t, 63);
      chk("to_err", ERR, 1);
      repeat (2) @(negedge CLK);
    end
`endif

    // Reset in the middle of a read transfer
    @(negedge CLK);
    idle_inputs();
    REQ[0] = 1; RQ_MASK[3:0] = 4'b1111; ADR[21:0] = 22'h000100;
    @(negedge CLK); REQ = '0;
    @(negedge CLK); MEM_ACKN_A = 1;
    @(negedge CLK); MEM_ACKN_A = 0; MEM_DATA_VALID_A = 1;
    @(negedge CLK);
    #1 chk("pre_rst_stb", WORD_STB, 1);
    #1 CROBAR_N = 0;
    #1 chk("rst_mid_outs", all_out(), 0);
    @(negedge CLK);
    idle_inputs();
    CROBAR_N = 1;
    last_r = 1;
    @(negedge CLK);
    REQ = 2'b11;
    expect_grant("rst_r0_first");
    @(negedge CLK);
    REQ = '0;
    repeat (3) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
